// File: rtl/ppu_reg_arbiter.sv
// Two-requester arbiter for the PPU CPU-side register window ($2000-$2007).
// Round-robin grants, a fixed access/recovery cadence, and a timed ownership lock.
module ppu_reg_arbiter #(
  parameter int unsigned RECOVERY_CYCLES = 1,
  parameter int unsigned LOCK_TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [2:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       a_write,
  input  logic       a_lock,
  output logic       a_ready,
  output logic       a_rvalid,
  output logic [7:0] a_rdata,
  input  logic       b_valid,
  input  logic [2:0] b_addr,
  input  logic [7:0] b_wdata,
  input  logic       b_write,
  input  logic       b_lock,
  output logic       b_ready,
  output logic       b_rvalid,
  output logic [7:0] b_rdata,
  output logic [2:0] ppu_address,
  output logic [7:0] ppu_data,
  input  logic [7:0] ppu_rdata,
  output logic       ppu_rw,
  output logic       ppu_cs
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic       HAS_RECOVERY = (RECOVERY_CYCLES != 0);
  localparam logic [3:0] REC_LAST     = (RECOVERY_CYCLES == 0) ? 4'd0 : 4'(RECOVERY_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_VAL  = 8'(LOCK_TIMEOUT);

  logic [1:0] state_r;
  logic [3:0] rec_cnt_r;
  logic       cmd_write_r;
  logic       cmd_lock_r;
  logic       cmd_port_r;
  logic       last_grant_r;
  logic       owner_valid_r;
  logic       owner_r;
  logic [7:0] to_cnt_r;

  logic       grant_a_s;
  logic       grant_b_s;
  logic       accept_s;
  logic       owner_req_s;
  logic       owner_idle_s;
  logic [7:0] to_next_s;
  logic [2:0] req_addr_s;
  logic [7:0] req_wdata_s;
  logic       req_write_s;
  logic       req_lock_s;

  // Grant decision: a lock owner excludes the other port, otherwise round-robin on ties
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if ((state_r == ST_IDLE) && !rst) begin
      if (owner_valid_r) begin
        if (owner_r == PORT_A) begin
          grant_a_s = a_valid;
        end else begin
          grant_b_s = b_valid;
        end
      end else if (a_valid && b_valid) begin
        if (last_grant_r == PORT_B) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else begin
        grant_a_s = a_valid;
        grant_b_s = b_valid;
      end
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  assign a_ready  = grant_a_s;
  assign b_ready  = grant_b_s;
  assign accept_s = grant_a_s | grant_b_s;

  // Request mux towards the command register
  always_comb begin
    req_addr_s  = a_addr;
    req_wdata_s = a_wdata;
    req_write_s = a_write;
    req_lock_s  = a_lock;
    if (grant_b_s) begin
      req_addr_s  = b_addr;
      req_wdata_s = b_wdata;
      req_write_s = b_write;
      req_lock_s  = b_lock;
    end else begin
      req_addr_s  = a_addr;
      req_wdata_s = a_wdata;
      req_write_s = a_write;
      req_lock_s  = a_lock;
    end
  end

  // Timeout only advances while the owner sits idle in IDLE
  always_comb begin
    owner_req_s = 1'b0;
    if (owner_r == PORT_B) begin
      owner_req_s = b_valid;
    end else begin
      owner_req_s = a_valid;
    end
    owner_idle_s = owner_valid_r && (state_r == ST_IDLE) && !owner_req_s;
    to_next_s    = to_cnt_r + 8'd1;
  end

  // Access sequencer: IDLE -> ACCESS -> RECOVER -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rec_cnt_r    <= 4'd0;
      cmd_write_r  <= 1'b0;
      cmd_lock_r   <= 1'b0;
      cmd_port_r   <= PORT_A;
      last_grant_r <= PORT_B;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_write_r  <= req_write_s;
            cmd_lock_r   <= req_lock_s;
            cmd_port_r   <= grant_b_s;
            last_grant_r <= grant_b_s;
            state_r      <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          rec_cnt_r <= 4'd0;
          state_r   <= HAS_RECOVERY ? ST_RECOVER : ST_IDLE;
        end
        ST_RECOVER: begin
          if (rec_cnt_r == REC_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            rec_cnt_r <= rec_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Ownership follows the lock bit of each completed access; idle owners time out
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_valid_r <= 1'b0;
      owner_r       <= PORT_A;
      to_cnt_r      <= 8'd0;
    end else if (state_r == ST_ACCESS) begin
      owner_valid_r <= cmd_lock_r;
      owner_r       <= cmd_port_r;
      to_cnt_r      <= 8'd0;
    end else if (owner_idle_s) begin
      if (to_next_s == TIMEOUT_VAL) begin
        owner_valid_r <= 1'b0;
        to_cnt_r      <= 8'd0;
      end else begin
        to_cnt_r <= to_next_s;
      end
    end else if (accept_s) begin
      to_cnt_r <= 8'd0;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // PPU bus: chip select is low only for the single ACCESS cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_cs      <= 1'b1;
      ppu_rw      <= 1'b0;
      ppu_address <= 3'd0;
      ppu_data    <= 8'd0;
    end else if (accept_s) begin
      ppu_cs      <= 1'b0;
      ppu_rw      <= req_write_s;
      ppu_address <= req_addr_s;
      ppu_data    <= req_write_s ? req_wdata_s : 8'd0;
    end else begin
      ppu_cs <= 1'b1;
    end
  end

  // Read return: capture at the end of ACCESS, rdata holds until the port's next read
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= 8'd0;
      b_rvalid <= 1'b0;
      b_rdata  <= 8'd0;
    end else if ((state_r == ST_ACCESS) && !cmd_write_r) begin
      if (cmd_port_r == PORT_B) begin
        b_rvalid <= 1'b1;
        b_rdata  <= ppu_rdata;
        a_rvalid <= 1'b0;
      end else begin
        a_rvalid <= 1'b1;
        a_rdata  <= ppu_rdata;
        b_rvalid <= 1'b0;
      end
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_reg_arbiter.sv
// Directed bench for ppu_reg_arbiter: per-cycle vector table plus hand-written
// sequences for lock pairing, lock timeout and reset during a read.
module tb_ppu_reg_arbiter;

  typedef struct packed {
    logic       v;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       write;
    logic       lock;
  } req_t;

  typedef struct {
    req_t        a;
    req_t        b;
    logic [7:0]  prd;
    logic [1:0]  rdy;   // {a_ready, b_ready}
    logic [12:0] ppu;   // {cs, rw, address, data}
    logic [1:0]  rv;    // {a_rvalid, b_rvalid}
    logic [7:0]  ard;
    logic [7:0]  brd;
  } vec_t;

  localparam req_t NONE = '0;
  localparam int NV = 27;

  logic       clk;
  logic       rst;
  logic       a_valid, a_write, a_lock, a_ready, a_rvalid;
  logic [2:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_valid, b_write, b_lock, b_ready, b_rvalid;
  logic [2:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic [2:0] ppu_address;
  logic [7:0] ppu_data, ppu_rdata;
  logic       ppu_rw, ppu_cs;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs [NV];

  ppu_reg_arbiter #(.RECOVERY_CYCLES(1), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_wdata(a_wdata), .a_write(a_write),
    .a_lock(a_lock), .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata), .b_write(b_write),
    .b_lock(b_lock), .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ppu_address(ppu_address), .ppu_data(ppu_data), .ppu_rdata(ppu_rdata),
    .ppu_rw(ppu_rw), .ppu_cs(ppu_cs)
  );

  always #5 clk = ~clk;

  function automatic req_t wr(input logic [2:0] ad, input logic [7:0] d, input logic lk);
    req_t r;
    r = '{v: 1'b1, addr: ad, wdata: d, write: 1'b1, lock: lk};
    return r;
  endfunction

  function automatic req_t rd(input logic [2:0] ad);
    req_t r;
    r = '{v: 1'b1, addr: ad, wdata: 8'h00, write: 1'b0, lock: 1'b0};
    return r;
  endfunction

  function automatic vec_t mk(input req_t ra, input req_t rb, input logic [7:0] prd,
                              input logic [1:0] rdy, input logic [12:0] ppu,
                              input logic [1:0] rv, input logic [7:0] ard, input logic [7:0] brd);
    vec_t t;
    t.a = ra; t.b = rb; t.prd = prd; t.rdy = rdy; t.ppu = ppu;
    t.rv = rv; t.ard = ard; t.brd = brd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, return at the following falling edge
  task automatic cycle_in(input req_t ra, input req_t rb, input logic [7:0] prd);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    a_valid   = ra.v; a_addr = ra.addr; a_wdata = ra.wdata; a_write = ra.write; a_lock = ra.lock;
    b_valid   = rb.v; b_addr = rb.addr; b_wdata = rb.wdata; b_write = rb.write; b_lock = rb.lock;
    ppu_rdata = prd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    a_valid = 1'b0; a_addr = 3'd0; a_wdata = 8'd0; a_write = 1'b0; a_lock = 1'b0;
    b_valid = 1'b0; b_addr = 3'd0; b_wdata = 8'd0; b_write = 1'b0; b_lock = 1'b0;
    ppu_rdata = 8'd0;

    // single write, spacing, read returns on A then B, round-robin, withdrawn request
    vecs[0]  = mk(NONE, NONE, 8'h00, 2'b00, {1'b1,1'b0,3'd0,8'h00}, 2'b00, 8'h00, 8'h00);
    vecs[1]  = mk(wr(3'd5,8'h28,1'b0), NONE, 8'h00, 2'b10, {1'b1,1'b0,3'd0,8'h00}, 2'b00, 8'h00, 8'h00);
    vecs[2]  = mk(NONE, NONE, 8'h00, 2'b00, {1'b0,1'b1,3'd5,8'h28}, 2'b00, 8'h00, 8'h00);
    vecs[3]  = mk(rd(3'd1), NONE, 8'h00, 2'b00, {1'b1,1'b1,3'd5,8'h28}, 2'b00, 8'h00, 8'h00);
    vecs[4]  = mk(rd(3'd1), NONE, 8'h00, 2'b10, {1'b1,1'b1,3'd5,8'h28}, 2'b00, 8'h00, 8'h00);
    vecs[5]  = mk(NONE, NONE, 8'h5A, 2'b00, {1'b0,1'b0,3'd1,8'h00}, 2'b00, 8'h00, 8'h00);
    vecs[6]  = mk(NONE, rd(3'd2), 8'h00, 2'b00, {1'b1,1'b0,3'd1,8'h00}, 2'b10, 8'h5A, 8'h00);
    vecs[7]  = mk(NONE, rd(3'd2), 8'h00, 2'b01, {1'b1,1'b0,3'd1,8'h00}, 2'b00, 8'h5A, 8'h00);
    vecs[8]  = mk(NONE, NONE, 8'h80, 2'b00, {1'b0,1'b0,3'd2,8'h00}, 2'b00, 8'h5A, 8'h00);
    vecs[9]  = mk(NONE, NONE, 8'h00, 2'b00, {1'b1,1'b0,3'd2,8'h00}, 2'b01, 8'h5A, 8'h80);
    vecs[10] = mk(NONE, NONE, 8'h00, 2'b00, {1'b1,1'b0,3'd2,8'h00}, 2'b00, 8'h5A, 8'h80);
    vecs[11] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b10, {1'b1,1'b0,3'd2,8'h00}, 2'b00, 8'h5A, 8'h80);
    vecs[12] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b00, {1'b0,1'b1,3'd0,8'h11}, 2'b00, 8'h5A, 8'h80);
    vecs[13] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b00, {1'b1,1'b1,3'd0,8'h11}, 2'b00, 8'h5A, 8'h80);
    vecs[14] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b01, {1'b1,1'b1,3'd0,8'h11}, 2'b00, 8'h5A, 8'h80);
    vecs[15] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b00, {1'b0,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[16] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b00, {1'b1,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[17] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b10, {1'b1,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[18] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b00, {1'b0,1'b1,3'd0,8'h11}, 2'b00, 8'h5A, 8'h80);
    vecs[19] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b00, {1'b1,1'b1,3'd0,8'h11}, 2'b00, 8'h5A, 8'h80);
    vecs[20] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b01, {1'b1,1'b1,3'd0,8'h11}, 2'b00, 8'h5A, 8'h80);
    vecs[21] = mk(wr(3'd7,8'h77,1'b0), NONE, 8'h00, 2'b00, {1'b0,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[22] = mk(wr(3'd7,8'h77,1'b0), NONE, 8'h00, 2'b00, {1'b1,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[23] = mk(NONE, NONE, 8'h00, 2'b00, {1'b1,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[24] = mk(NONE, NONE, 8'h00, 2'b00, {1'b1,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[25] = mk(wr(3'd0,8'h11,1'b0), wr(3'd3,8'h22,1'b0), 8'h00, 2'b10, {1'b1,1'b1,3'd3,8'h22}, 2'b00, 8'h5A, 8'h80);
    vecs[26] = mk(NONE, NONE, 8'h00, 2'b00, {1'b0,1'b1,3'd0,8'h11}, 2'b00, 8'h5A, 8'h80);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      cycle_in(vecs[i].a, vecs[i].b, vecs[i].prd);
      chk($sformatf("vec%0d ready", i), {30'd0, a_ready, b_ready}, {30'd0, vecs[i].rdy});
      chk($sformatf("vec%0d ppu", i), {19'd0, ppu_cs, ppu_rw, ppu_address, ppu_data}, {19'd0, vecs[i].ppu});
      chk($sformatf("vec%0d rvalid", i), {30'd0, a_rvalid, b_rvalid}, {30'd0, vecs[i].rv});
      chk($sformatf("vec%0d a_rdata", i), {24'd0, a_rdata}, {24'd0, vecs[i].ard});
      chk($sformatf("vec%0d b_rdata", i), {24'd0, b_rdata}, {24'd0, vecs[i].brd});
    end

    // lock pairing: both A writes to $2006 complete before B gets the bus
    do_reset();
    cycle_in(wr(3'd6,8'h12,1'b1), wr(3'd4,8'h44,1'b0), 8'h00);
    chk("lock first grant", {a_ready, b_ready}, 2'b10);
    cycle_in(wr(3'd6,8'h34,1'b0), wr(3'd4,8'h44,1'b0), 8'h00);
    chk("lock first access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b1,3'd6,8'h12});
    cycle_in(wr(3'd6,8'h34,1'b0), wr(3'd4,8'h44,1'b0), 8'h00);
    chk("lock recover ready", {a_ready, b_ready}, 2'b00);
    cycle_in(wr(3'd6,8'h34,1'b0), wr(3'd4,8'h44,1'b0), 8'h00);
    chk("lock owner regrant", {a_ready, b_ready}, 2'b10);
    cycle_in(NONE, wr(3'd4,8'h44,1'b0), 8'h00);
    chk("lock second access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b1,3'd6,8'h34});
    cycle_in(NONE, wr(3'd4,8'h44,1'b0), 8'h00);
    chk("lock second recover", {a_ready, b_ready}, 2'b00);
    cycle_in(NONE, wr(3'd4,8'h44,1'b0), 8'h00);
    chk("lock release b grant", {a_ready, b_ready}, 2'b01);
    cycle_in(NONE, NONE, 8'h00);
    chk("lock b access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b1,3'd4,8'h44});

    // lock timeout: idle owner A is force-released after 4 idle cycles
    do_reset();
    cycle_in(wr(3'd5,8'h01,1'b1), wr(3'd4,8'h44,1'b0), 8'h00);
    chk("timeout lock grant", {a_ready, b_ready}, 2'b10);
    cycle_in(NONE, wr(3'd4,8'h44,1'b0), 8'h00);
    chk("timeout lock access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b1,3'd5,8'h01});
    cycle_in(NONE, wr(3'd4,8'h44,1'b0), 8'h00);
    chk("timeout recover", {a_ready, b_ready}, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      cycle_in(NONE, wr(3'd4,8'h44,1'b0), 8'h00);
      chk($sformatf("timeout idle %0d", k), {a_ready, b_ready}, 2'b00);
    end
    cycle_in(NONE, wr(3'd4,8'h44,1'b0), 8'h00);
    chk("timeout b grant", {a_ready, b_ready}, 2'b01);
    cycle_in(NONE, NONE, 8'h00);
    chk("timeout b access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b1,3'd4,8'h44});

    // reset lands during the ACCESS cycle of an A read
    do_reset();
    cycle_in(rd(3'd2), NONE, 8'h00);
    chk("rst read grant", {a_ready, b_ready}, 2'b10);
    cycle_in(NONE, NONE, 8'h99);
    chk("rst read access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b0,3'd2,8'h00});
    rst = 1'b1;
    cycle_in(wr(3'd1,8'hAB,1'b0), wr(3'd3,8'hCD,1'b0), 8'h99);
    chk("rst cs high", {31'd0, ppu_cs}, 32'd1);
    chk("rst rvalid 0", {a_rvalid, b_rvalid}, 2'b00);
    chk("rst a_rdata", a_rdata, 8'h00);
    chk("rst first tie", {a_ready, b_ready}, 2'b10);
    cycle_in(wr(3'd1,8'hAB,1'b0), wr(3'd3,8'hCD,1'b0), 8'h99);
    chk("rst post access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b1,3'd1,8'hAB});
    chk("rst rvalid 1", {a_rvalid, b_rvalid}, 2'b00);
    cycle_in(wr(3'd1,8'hAB,1'b0), wr(3'd3,8'hCD,1'b0), 8'h99);
    chk("rst rvalid 2", {a_rvalid, b_rvalid}, 2'b00);
    cycle_in(wr(3'd1,8'hAB,1'b0), wr(3'd3,8'hCD,1'b0), 8'h99);
    chk("rst rr b grant", {a_ready, b_ready}, 2'b01);
    cycle_in(NONE, NONE, 8'h00);
    chk("rst rr b access", {ppu_cs, ppu_rw, ppu_address, ppu_data}, {1'b0,1'b1,3'd3,8'hCD});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
